mips_cpu_divider: RTL

- Multi-cycle restoring divider inside mips_cpu_bus; executes DIV and DIVU.
- Fed by the decode/execute stage (operands rs, rt plus a signed flag). Produces quotient → LO and remainder → HI.
- The control FSM stalls on busy and writes HI/LO on done.
- Fixed latency independent of operand values, except the optional zero-divisor fast path.

---
 rtl/mips_cpu_pkg.sv | 14 +
 rtl/mips_cpu_divider_if.sv | 25 ++
 rtl/mips_cpu_divider.sv | 138 +++++++++++++
 3 files changed

// File: rtl/mips_cpu_pkg.sv
// rtl/mips_cpu_pkg.sv - shared types and constants for the mips_cpu divider
package mips_cpu_pkg;

  typedef enum logic [1:0] {
    IDLE,
    RUN,
    FIX,
    DONE
  } div_state_t;

  localparam int          DIV_ITERATIONS    = 32;
  localparam logic [31:0] DIV_ZERO_QUOTIENT = 32'hFFFF_FFFF;

endpackage

// File: rtl/mips_cpu_divider_if.sv
// rtl/mips_cpu_divider_if.sv - request/result bundle between execute stage and divider
interface mips_cpu_divider_if #(
  parameter int WIDTH = 32
);

  logic             start;
  logic             is_signed;
  logic [WIDTH-1:0] dividend;
  logic [WIDTH-1:0] divisor;
  logic             busy;
  logic             done;
  logic [WIDTH-1:0] quotient;
  logic [WIDTH-1:0] remainder;

  modport master (
    output start, is_signed, dividend, divisor,
    input  busy, done, quotient, remainder
  );

  modport slave (
    input  start, is_signed, dividend, divisor,
    output busy, done, quotient, remainder
  );

endinterface

// File: rtl/mips_cpu_divider.sv
// rtl/mips_cpu_divider.sv - multi-cycle restoring DIV/DIVU unit
// Optional MIPS_CPU_DIV_ZERO_FASTPATH_EN: zero divisor skips RUN and goes straight to FIX.
module mips_cpu_divider
  import mips_cpu_pkg::*;
#(
  parameter int WIDTH = 32
) (
  input logic               clk,
  input logic               reset,
  mips_cpu_divider_if.slave div
);

  localparam int CNT_W = $clog2(DIV_ITERATIONS);

  div_state_t       state_q, state_d;
  logic [CNT_W-1:0] cnt_q, cnt_d;
  logic [WIDTH-1:0] rem_q, rem_d;
  logic [WIDTH-1:0] quo_q, quo_d;
  logic [WIDTH-1:0] dvs_q, dvs_d;
  logic             q_neg_q, q_neg_d;
  logic             r_neg_q, r_neg_d;
  logic             zero_q, zero_d;
  logic             busy_q, busy_d;
  logic             done_q, done_d;
  logic [WIDTH-1:0] quotient_q, quotient_d;
  logic [WIDTH-1:0] remainder_q, remainder_d;

  logic             dvd_neg, dvs_neg;
  logic [WIDTH-1:0] dvd_abs, dvs_abs;
  logic [WIDTH:0]   shifted, trial;

  always_comb begin
    dvd_neg = div.is_signed & div.dividend[WIDTH-1];
    dvs_neg = div.is_signed & div.divisor[WIDTH-1];
    dvd_abs = dvd_neg ? -div.dividend : div.dividend;
    dvs_abs = dvs_neg ? -div.divisor : div.divisor;
    // quo_q holds the remaining dividend bits; its MSB feeds the partial remainder
    shifted = {rem_q, quo_q[WIDTH-1]};
    trial   = shifted - {1'b0, dvs_q};

    state_d     = state_q;
    cnt_d       = cnt_q;
    rem_d       = rem_q;
    quo_d       = quo_q;
    dvs_d       = dvs_q;
    q_neg_d     = q_neg_q;
    r_neg_d     = r_neg_q;
    zero_d      = zero_q;
    busy_d      = busy_q;
    done_d      = done_q;
    quotient_d  = quotient_q;
    remainder_d = remainder_q;

    case (state_q)
      IDLE: begin
        if (div.start) begin
          rem_d   = '0;
          quo_d   = dvd_abs;
          dvs_d   = dvs_abs;
          q_neg_d = dvd_neg ^ dvs_neg;
          r_neg_d = dvd_neg;
          zero_d  = (div.divisor == '0);
          cnt_d   = '0;
          busy_d  = 1'b1;
          state_d = RUN;
`ifdef MIPS_CPU_DIV_ZERO_FASTPATH_EN
          if (div.divisor == '0) begin
            rem_d   = dvd_abs;
            state_d = FIX;
          end
`endif
        end
      end
      RUN: begin
        if (!trial[WIDTH]) begin
          rem_d = trial[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b1};
        end else begin
          rem_d = shifted[WIDTH-1:0];
          quo_d = {quo_q[WIDTH-2:0], 1'b0};
        end
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == CNT_W'(DIV_ITERATIONS - 1)) begin
          state_d = FIX;
        end
      end
      FIX: begin
        // Zero divisor: sign fix-up of |dividend| restores the original dividend
        quotient_d  = zero_q ? DIV_ZERO_QUOTIENT[WIDTH-1:0] : (q_neg_q ? -quo_q : quo_q);
        remainder_d = r_neg_q ? -rem_q : rem_q;
        done_d      = 1'b1;
        busy_d      = 1'b0;
        state_d     = DONE;
      end
      DONE: begin
        done_d  = 1'b0;
        state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state_q     <= IDLE;
      cnt_q       <= '0;
      rem_q       <= '0;
      quo_q       <= '0;
      dvs_q       <= '0;
      q_neg_q     <= 1'b0;
      r_neg_q     <= 1'b0;
      zero_q      <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      quotient_q  <= '0;
      remainder_q <= '0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      rem_q       <= rem_d;
      quo_q       <= quo_d;
      dvs_q       <= dvs_d;
      q_neg_q     <= q_neg_d;
      r_neg_q     <= r_neg_d;
      zero_q      <= zero_d;
      busy_q      <= busy_d;
      done_q      <= done_d;
      quotient_q  <= quotient_d;
      remainder_q <= remainder_d;
    end
  end

  assign div.busy      = busy_q;
  assign div.done      = done_q;
  assign div.quotient  = quotient_q;
  assign div.remainder = remainder_q;

endmodule
